// File: rtl/float2int_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : float2int_seq_if
//  Purpose  : Request/result handshake bundle for the sequential
//             mini-float to integer converter.
//  Revision : 1.0 - initial release
// ============================================================================
interface float2int_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_float;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_int;
    logic        busy;

    // Producer/consumer side: issues requests and takes results
    modport master (
        output in_valid,
        output in_float,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_int,
        input  busy
    );

    // Converter side
    modport slave (
        input  in_valid,
        input  in_float,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_int,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/float2int_seq.sv
`default_nettype none
// ============================================================================
//  Module   : float2int_seq
//  Purpose  : Converts a 7-bit mini-float (3-bit exponent, 4-bit mantissa)
//             into an exact 11-bit unsigned integer by shifting the
//             significand STEP positions per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module float2int_seq #(
    parameter int STEP = 1          // shift positions per cycle: 1, 2, 3 or 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    float2int_seq_if.slave     bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] C_STEP  = 3'(STEP);

    logic [1:0]  r_state;
    logic [10:0] r_sig;        // significand; doubles as the visible result
    logic [2:0]  r_rem;        // remaining left-shift positions
    logic        r_out_valid;
    logic        r_busy;

    logic [2:0]  w_exp;
    logic [3:0]  w_man;
    logic [10:0] w_load_sig;
    logic [2:0]  w_load_rem;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_deliver;
    logic [2:0]  w_amt;
    logic [10:0] w_shifted;
    logic [2:0]  w_rem_next;

    // Request decode, handshake qualification and the per-cycle shift step
    always_comb begin
        w_exp      = bus.in_float[6:4];
        w_man      = bus.in_float[3:0];
        // Denormals carry no hidden bit and need no shift
        w_load_sig = (w_exp == 3'd0) ? {7'd0, w_man} : {6'd0, 1'b1, w_man};
        w_load_rem = (w_exp == 3'd0) ? 3'd0 : (w_exp - 3'd1);
        // A finished result being taken frees the block for a new request
        // on the same edge, so in_ready never looks at in_valid
        w_in_ready = (r_state == S_IDLE) ||
                     ((r_state == S_DONE) && bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
        w_deliver  = r_out_valid && bus.out_ready;
        w_amt      = (r_rem < C_STEP) ? r_rem : C_STEP;
        w_shifted  = r_sig << w_amt;
        w_rem_next = r_rem - w_amt;
    end

    // Control state, significand shifting and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sig       <= 11'd0;
            r_rem       <= 3'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Accept is only possible from IDLE or from DONE while the old
            // result is being delivered on this very edge
            r_sig  <= w_load_sig;
            r_rem  <= w_load_rem;
            r_busy <= 1'b1;
            if (w_load_rem == 3'd0) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= S_SHIFT;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_sig <= w_shifted;
                    r_rem <= w_rem_next;
                    if (w_rem_next == 3'd0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_deliver) begin
                        r_state     <= S_IDLE;
                        r_sig       <= 11'd0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                S_IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sig       <= 11'd0;
                    r_rem       <= 3'd0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_int   = r_sig;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_float2int_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float2int_seq
//  Purpose  : Self-checking bench for float2int_seq; two instances
//             (STEP=1 and STEP=2) driven through their interfaces.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_float2int_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    float2int_seq_if bus0();
    float2int_seq_if bus1();

    float2int_seq #(.STEP(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    float2int_seq #(.STEP(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Index-addressable views of both instances
    logic [1:0]  iv   = 2'b00;
    logic [1:0]  ordy = 2'b00;
    logic [6:0]  ifl [2];
    logic [1:0]  irdy, ov, bsy;
    logic [10:0] oi  [2];

    assign bus0.in_valid  = iv[0];
    assign bus0.in_float  = ifl[0];
    assign bus0.out_ready = ordy[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.in_float  = ifl[1];
    assign bus1.out_ready = ordy[1];
    assign irdy[0] = bus0.in_ready;
    assign irdy[1] = bus1.in_ready;
    assign ov[0]   = bus0.out_valid;
    assign ov[1]   = bus1.out_valid;
    assign bsy[0]  = bus0.busy;
    assign bsy[1]  = bus1.busy;
    assign oi[0]   = bus0.out_int;
    assign oi[1]   = bus1.out_int;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] src_q [$];

    // Reference: value of the mini-float by its arithmetic definition
    function automatic logic [10:0] ref_val(input logic [6:0] f);
        int e = int'(f[6:4]);
        int m = int'(f[3:0]);
        if (e == 0) return 11'(m);
        return 11'((16 + m) * (1 << (e - 1)));
    endfunction

    // Reference: cycles from accept edge to first out_valid
    function automatic int ref_lat(input logic [6:0] f, input int step);
        int e = int'(f[6:4]);
        int r = (e == 0) ? 0 : e - 1;
        return 1 + (r + step - 1) / step;
    endfunction

    function automatic int step_of(input int idx);
        return (idx == 0) ? 1 : 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request with optional backpressure on the result
    task automatic run_one(input int idx, input logic [6:0] f, input int hold);
        int cyc;
        logic [10:0] expv;
        expv = ref_val(f);
        iv[idx] = 1'b1; ifl[idx] = f; ordy[idx] = 1'b0;
        #1;
        n_checks++;
        if (irdy[idx] !== 1'b1) $display("FAIL idle_ready[%0d]: got %b want 1", idx, irdy[idx]);
        else n_pass++;
        tick();
        iv[idx] = 1'b0;
        cyc = 1;
        while (ov[idx] !== 1'b1 && cyc < 20) begin
            n_checks++;
            if (bsy[idx] !== 1'b1 || irdy[idx] !== 1'b0)
                $display("FAIL shift_flags[%0d] f=%h cyc=%0d: busy=%b in_ready=%b want 1/0",
                         idx, f, cyc, bsy[idx], irdy[idx]);
            else n_pass++;
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != ref_lat(f, step_of(idx)))
            $display("FAIL latency[%0d] f=%h: got %0d want %0d", idx, f, cyc, ref_lat(f, step_of(idx)));
        else n_pass++;
        n_checks++;
        if (oi[idx] !== expv || bsy[idx] !== 1'b1)
            $display("FAIL result[%0d] f=%h: got %0d busy=%b want %0d busy=1", idx, f, oi[idx], bsy[idx], expv);
        else n_pass++;
        repeat (hold) begin
            tick();
            n_checks++;
            if (ov[idx] !== 1'b1 || oi[idx] !== expv || irdy[idx] !== 1'b0)
                $display("FAIL hold[%0d] f=%h: valid=%b int=%0d in_ready=%b want 1/%0d/0",
                         idx, f, ov[idx], oi[idx], irdy[idx], expv);
            else n_pass++;
        end
        ordy[idx] = 1'b1;
        #1;
        n_checks++;
        if (irdy[idx] !== 1'b1) $display("FAIL done_ready[%0d]: got %b want 1", idx, irdy[idx]);
        else n_pass++;
        tick();
        ordy[idx] = 1'b0;
        n_checks++;
        if (ov[idx] !== 1'b0 || oi[idx] !== 11'd0 || bsy[idx] !== 1'b0)
            $display("FAIL after_delivery[%0d]: valid=%b int=%0d busy=%b want 0/0/0",
                     idx, ov[idx], oi[idx], bsy[idx]);
        else n_pass++;
    endtask

    // Streams src_q through one instance and scoreboards the results
    task automatic stream(input int idx, input bit rand_mode);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int n;
        logic [10:0] exp_q [$];
        logic [10:0] val, expv;
        bit acc, del, hold;
        n = src_q.size();
        while (got < n && cyc < 3000) begin
            ordy[idx] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < n && (!rand_mode || $urandom_range(0, 1) == 1)) begin
                iv[idx] = 1'b1; ifl[idx] = src_q[sent];
            end else begin
                iv[idx] = 1'b0;
            end
            #1;
            acc  = iv[idx] && irdy[idx];
            del  = ov[idx] && ordy[idx];
            hold = ov[idx] && !ordy[idx];
            val  = oi[idx];
            if (!rand_mode && ov[idx] === 1'b1) begin
                n_checks++;
                if (irdy[idx] !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", idx, irdy[idx]);
                else n_pass++;
            end
            tick();
            cyc++;
            if (del) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                n_checks++;
                if (val !== expv) $display("FAIL stream[%0d] item %0d: got %0d want %0d", idx, got, val, expv);
                else n_pass++;
                got++;
            end
            if (acc) begin
                exp_q.push_back(ref_val(src_q[sent]));
                sent++;
            end
            if (hold) begin
                n_checks++;
                if (ov[idx] !== 1'b1 || oi[idx] !== val)
                    $display("FAIL stall_hold[%0d]: valid=%b int=%0d want 1/%0d", idx, ov[idx], oi[idx], val);
                else n_pass++;
            end
        end
        iv[idx] = 1'b0; ordy[idx] = 1'b0;
        n_checks++;
        if (got != n || sent != n) $display("FAIL stream_count[%0d]: got %0d sent %0d want %0d", idx, got, sent, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 2'b11; ifl[0] = 7'h7F; ifl[1] = 7'h7F; ordy = 2'b11;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ov[i] !== 1'b0 || oi[i] !== 11'd0 || bsy[i] !== 1'b0)
                $display("FAIL reset_state[%0d]: valid=%b int=%0d busy=%b want 0/0/0", i, ov[i], oi[i], bsy[i]);
            else n_pass++;
        end
        rst = 1'b0; iv = 2'b00; ordy = 2'b00;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (irdy[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", i, irdy[i]);
            else n_pass++;
        end
    endtask

    task automatic test_denormal();
        run_one(0, 7'h09, 0);
    endtask

    task automatic test_max();
        run_one(0, 7'h7F, 0);
    endtask

    task automatic test_step2();
        run_one(1, 7'h45, 0);
        run_one(1, 7'h7F, 0);
    endtask

    task automatic test_backpressure();
        run_one(0, 7'h10, 5);
    endtask

    task automatic test_back_to_back();
        src_q = '{7'h10, 7'h20, 7'h00};
        stream(0, 1'b0);
    endtask

    task automatic test_reset_mid();
        iv[0] = 1'b1; ifl[0] = 7'h7F; ordy[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        n_checks++;
        if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) $display("FAIL mid_shift: busy=%b valid=%b want 1/0", bsy[0], ov[0]);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0 || oi[0] !== 11'd0 || bsy[0] !== 1'b0 || irdy[0] !== 1'b1)
            $display("FAIL mid_reset: valid=%b int=%0d busy=%b in_ready=%b want 0/0/0/1",
                     ov[0], oi[0], bsy[0], irdy[0]);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) $display("FAIL discarded: valid=%b busy=%b want 0/0", ov[0], bsy[0]);
        else n_pass++;
        ordy[0] = 1'b0;
        run_one(0, 7'h13, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            src_q.delete();
            for (int k = 0; k < 60; k++) src_q.push_back(7'($urandom_range(0, 127)));
            stream(i, 1'b1);
        end
    endtask

    initial begin
        ifl[0] = 7'h00; ifl[1] = 7'h00;
        test_reset();
        test_denormal();
        test_max();
        test_step2();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float2int_seq.md
FLOAT2INT_SEQ -- requirements
Module: float2int_seq

Interface
REQ-001 SHALL have parameter: STEP, 1, shift positions applied per cycle; legal values 1, 2, 3, 6.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port: in_valid  input  1  in_float holds a conversion request.
REQ-005 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port: in_float  input  7  packed float: [6:4] exponent e, [3:0] mantissa m.
REQ-007 SHALL have port: out_valid  output  1  out_int holds a finished result.
REQ-008 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port: out_int  output  11  unsigned integer result.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL decode the value as follows: e=0 gives m (denormal, 0..15); e>=1 gives (16+m) << (e-1); the maximum is e=7, m=15, which gives 1984.
REQ-012 SHALL compute the exact result with no rounding, saturation or overflow; all results fit in 11 bits.
REQ-013 SHALL treat an accept as the rising edge where in_valid=1 and in_ready=1.
REQ-014 SHALL treat a delivery as the rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL implement the states IDLE, SHIFT and DONE.
REQ-016 SHALL, on accept, load the significand register (m for e=0, 16+m otherwise) and the remaining-shift counter r = max(e-1, 0).
REQ-017 SHALL, on accept, go to DONE if r=0 and to SHIFT otherwise.
REQ-018 SHALL, in SHIFT, on each cycle left-shift the significand by min(STEP, r) and decrement r by the same amount, going to DONE when r reaches 0.
REQ-019 SHALL give latency from the accept edge to the first cycle with out_valid=1 of 1 + ceil(r/STEP) cycles (STEP=1, e=7: 7 cycles; e<=1: 1 cycle).
REQ-020 SHALL drive out_valid=1 only in DONE.
REQ-021 SHALL hold out_int stable while out_valid=1 and out_ready=0.
REQ-022 SHALL leave out_int undefined-free in all states: it is zero in IDLE and shows the partial shift value in SHIFT.
REQ-023 SHALL drive in_ready=1 in IDLE, and also in DONE when out_ready=1 (back-to-back accept at the delivery edge); in_ready SHALL be 0 in SHIFT.
REQ-024 SHALL, on delivery without a simultaneous accept, go from DONE to IDLE and clear out_int to 0.
REQ-025 SHALL, on a simultaneous delivery and accept, deliver the old result and load the new request on the same edge, following REQ-016 and REQ-017.
REQ-026 SHALL ignore in_float whenever in_ready=0; no request SHALL be lost or duplicated.
REQ-027 SHALL compute in_ready combinationally from state and out_ready only; it SHALL NOT depend on in_valid.
REQ-028 SHALL register out_valid, out_int and busy directly.

Reset
REQ-029 SHALL, while rst=1 at an edge, force the state to IDLE, r=0, significand=0, out_int=0, out_valid=0 and busy=0; in_ready SHALL be 1 from the following cycle.
REQ-030 SHALL let reset win over every simultaneous event (accept, delivery, shift); an in-flight conversion is discarded and never delivered.
REQ-031 SHALL accept no request on an edge where rst=1.

Verification
REQ-032 SHALL cover, with STEP=1: in_float=0x09 (e=0, m=9) accepted -> out_valid=1 one cycle later with out_int=9.
REQ-033 SHALL cover, with STEP=1: in_float=0x7F accepted -> busy=1, in_ready=0 for cycles 1-6, out_valid=1 at cycle 7 with out_int=1984.
REQ-034 SHALL cover, with STEP=2: in_float=0x45 (e=4, m=5) accepted -> out_int=168 after 3 cycles (ceil(3/2)=2 shift cycles).
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles after a result for 0x10 -> out_int stays 16 and out_valid stays 1; in_ready=0 throughout; the result is delivered when out_ready rises.
REQ-036 SHALL cover back-to-back traffic: stream 0x10, 0x20, 0x00 with out_ready=1 -> results 16, 32, 0 in order with no bubble at the DONE-to-accept edge.
REQ-037 SHALL cover reset mid-operation: rst=1 during SHIFT of 0x7F -> next cycle state IDLE, out_valid=0, out_int=0; the next request 0x13 returns 19 correctly.
